// File: rtl/svm_sched_pkg.sv
// Shared scheduler types: batch FSM encoding and program-ID width.
package svm_sched_pkg;
  localparam int PROGRAM_ID_W = 64;

  typedef logic state_t;
  localparam state_t ACCUM = 1'b0;
  localparam state_t EMIT  = 1'b1;
endpackage

// File: rtl/dep_conflict_check.sv
// Pure combinational RAW/WAW/WAR hazard test of one txn against a batch's read/write masks.
module dep_conflict_check #(
  parameter int W = 1024
) (
  input  logic [W-1:0] rd_in,
  input  logic [W-1:0] wr_in,
  input  logic [W-1:0] batch_rd,
  input  logic [W-1:0] batch_wr,
  output logic         conflict
);
  assign conflict = (|(rd_in & batch_wr)) | (|(wr_in & batch_wr)) | (|(wr_in & batch_rd));
endmodule

// File: rtl/batch_builder.sv
// Packs conflict-free txns into batches; closes on full, timeout or conflict stall; emits on valid/ready.
// Full batch is valid the cycle after its last accept; input is held off while a batch waits downstream.
module batch_builder
  import svm_sched_pkg::*;
#(
  parameter int MAX_DEPENDENCIES = 1024,
  parameter int MAX_BATCH_SIZE   = 8,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  input  logic [PROGRAM_ID_W-1:0]                  s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0]              s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0]              s_axis_tdata_write_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]              batch_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]              batch_write_dependencies,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic [$clog2(MAX_BATCH_SIZE+1)-1:0]      m_axis_tdata_batch_size,
  output logic [PROGRAM_ID_W*MAX_BATCH_SIZE-1:0]   m_axis_tdata_program_ids,
  output logic [MAX_DEPENDENCIES-1:0]              m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]              m_axis_tdata_write_dependencies,
  output logic [31:0]                              batches_emitted,
  output logic [31:0]                              conflict_closes,
  output logic [31:0]                              timeout_closes
);
  localparam int CW = $clog2(MAX_BATCH_SIZE + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t                      state, state_nxt;
  logic [CW-1:0]               count;
  logic [TW-1:0]               timer;
  logic [MAX_DEPENDENCIES-1:0] rd_mask, wr_mask;
  logic [PROGRAM_ID_W-1:0]     slot [MAX_BATCH_SIZE];

  logic conflict, busy, stall, accept, full_close, timeout_hit, handshake;

  dep_conflict_check #(.W(MAX_DEPENDENCIES)) u_conflict (
    .rd_in    (s_axis_tdata_read_dependencies),
    .wr_in    (s_axis_tdata_write_dependencies),
    .batch_rd (rd_mask),
    .batch_wr (wr_mask),
    .conflict (conflict)
  );

  assign busy        = (count != '0);
  assign stall       = s_axis_tvalid && conflict && busy;
  assign accept      = s_axis_tvalid && s_axis_tready;
  assign full_close  = accept && (count == CW'(MAX_BATCH_SIZE - 1));
  assign timeout_hit = busy && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign handshake   = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (full_close || stall || timeout_hit) state_nxt = EMIT;
      EMIT:    if (handshake) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    s_axis_tready = 1'b0;
    if (state == EMIT) m_axis_tvalid = 1'b1;
    else s_axis_tready = (count < CW'(MAX_BATCH_SIZE)) && !stall;
  end

  // Timer only runs once the batch holds a txn, so the first accept leaves it at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count           <= '0;
      timer           <= '0;
      rd_mask         <= '0;
      wr_mask         <= '0;
      batches_emitted <= '0;
      conflict_closes <= '0;
      timeout_closes  <= '0;
    end else if (handshake) begin
      count           <= '0;
      timer           <= '0;
      rd_mask         <= '0;
      wr_mask         <= '0;
      batches_emitted <= batches_emitted + 32'd1;
    end else if (state == ACCUM) begin
      if (accept) begin
        count   <= count + 1'b1;
        rd_mask <= rd_mask | s_axis_tdata_read_dependencies;
        wr_mask <= wr_mask | s_axis_tdata_write_dependencies;
      end
      if (busy) timer <= timer + 1'b1;
      if (!full_close) begin
        if (stall)            conflict_closes <= conflict_closes + 32'd1;
        else if (timeout_hit) timeout_closes  <= timeout_closes + 32'd1;
      end
    end
  end

  for (genvar k = 0; k < MAX_BATCH_SIZE; k++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst || handshake)              slot[k] <= '0;
      else if (accept && count == CW'(k)) slot[k] <= s_axis_tdata_owner_programID;
    end
    assign m_axis_tdata_program_ids[k*PROGRAM_ID_W +: PROGRAM_ID_W] = slot[k];
  end

  assign batch_read_dependencies         = rd_mask;
  assign batch_write_dependencies        = wr_mask;
  assign m_axis_tdata_read_dependencies  = rd_mask;
  assign m_axis_tdata_write_dependencies = wr_mask;
  assign m_axis_tdata_batch_size         = count;
endmodule

// File: tb/tb_batch_builder.sv
// Directed scenarios plus randomized traffic against a queue-based batch model.
module tb_batch_builder;
  localparam int MD = 16;
  localparam int MB = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [63:0]   s_id = '0;
  logic [MD-1:0] s_rd = '0, s_wr = '0;
  logic [MD-1:0] b_rd, b_wr;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [2:0]    m_size;
  logic [255:0]  m_ids;
  logic [MD-1:0] m_rd, m_wr;
  logic [31:0]   n_emit, n_conf, n_to;

  always #5 clk = ~clk;

  batch_builder #(.MAX_DEPENDENCIES(MD), .MAX_BATCH_SIZE(MB), .TIMEOUT_CYCLES(TO)) dut (
    .clk                             (clk),
    .rst                             (rst),
    .s_axis_tvalid                   (s_tvalid),
    .s_axis_tready                   (s_tready),
    .s_axis_tdata_owner_programID    (s_id),
    .s_axis_tdata_read_dependencies  (s_rd),
    .s_axis_tdata_write_dependencies (s_wr),
    .batch_read_dependencies         (b_rd),
    .batch_write_dependencies        (b_wr),
    .m_axis_tvalid                   (m_tvalid),
    .m_axis_tready                   (m_tready),
    .m_axis_tdata_batch_size         (m_size),
    .m_axis_tdata_program_ids        (m_ids),
    .m_axis_tdata_read_dependencies  (m_rd),
    .m_axis_tdata_write_dependencies (m_wr),
    .batches_emitted                 (n_emit),
    .conflict_closes                 (n_conf),
    .timeout_closes                  (n_to)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the open batch is a queue of IDs plus set unions; age is cycles since first insert.
  logic [63:0]   q_ids[$];
  logic [MD-1:0] q_rd = '0, q_wr = '0;
  int            cyc = 0, t_first = 0;
  bit            emitting = 0;
  int unsigned   c_emit = 0, c_conf = 0, c_to = 0;

  task automatic model_clear_batch();
    q_ids.delete();
    q_rd = '0;
    q_wr = '0;
  endtask

  task automatic step(input bit v, input logic [63:0] id, input logic [MD-1:0] rd,
                      input logic [MD-1:0] wr, input bit mr, input bit r);
    bit conf, stall, rdy, acc, tmo, was_busy;
    logic [255:0] e_ids;
    rst = r; s_tvalid = v; s_id = id; s_rd = rd; s_wr = wr; m_tready = mr;
    @(negedge clk);
    conf  = ((rd & q_wr) != 0) || ((wr & q_wr) != 0) || ((wr & q_rd) != 0);
    stall = v && conf && (q_ids.size() != 0);
    rdy   = !emitting && (q_ids.size() < MB) && !stall;
    check_val("s_tready", s_tready, rdy);
    check_val("m_tvalid", m_tvalid, emitting);
    check_val("batch_rd", b_rd, q_rd);
    check_val("batch_wr", b_wr, q_wr);
    check_val("emitted", n_emit, c_emit);
    check_val("conf_closes", n_conf, c_conf);
    check_val("tmo_closes", n_to, c_to);
    if (emitting) begin
      e_ids = '0;
      foreach (q_ids[k]) e_ids[k*64 +: 64] = q_ids[k];
      check_val("m_size", m_size, q_ids.size());
      check_val("m_ids", m_ids, e_ids);
      check_val("m_rd", m_rd, q_rd);
      check_val("m_wr", m_wr, q_wr);
    end
    @(posedge clk);
    if (r) begin
      model_clear_batch();
      emitting = 0; c_emit = 0; c_conf = 0; c_to = 0;
    end else if (emitting) begin
      if (mr) begin
        c_emit++;
        model_clear_batch();
        emitting = 0;
      end
    end else begin
      acc      = v && rdy;
      was_busy = q_ids.size() != 0;
      tmo      = was_busy && (cyc - t_first == TO);
      if (acc) begin
        if (!was_busy) t_first = cyc;
        q_ids.push_back(id);
        q_rd |= rd;
        q_wr |= wr;
      end
      if (acc && q_ids.size() == MB) emitting = 1;
      else if (stall) begin c_conf++; emitting = 1; end
      else if (tmo)   begin c_to++;   emitting = 1; end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, 1, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(0, '0, '0, '0, 1, 1);

    // Fill: four disjoint txns back-to-back
    for (int k = 0; k < 4; k++)
      step(1, 64'(k + 1), 16'(1) << k, 16'h0100 << k, 1, 0);
    check_val("fill_vld", m_tvalid, 1);
    check_val("fill_size", m_size, 4);
    check_val("fill_ids", m_ids, {64'd4, 64'd3, 64'd2, 64'd1});
    check_val("fill_rd", m_rd, 16'h000F);
    check_val("fill_wr", m_wr, 16'h0F00);
    idle(1);
    check_val("fill_emit", n_emit, 1);

    // Conflict stall closes a one-txn batch
    step(1, 64'hA, 16'h0000, 16'h0002, 1, 0);
    step(1, 64'hB, 16'h0002, 16'h0000, 1, 0);
    check_val("conf_vld", m_tvalid, 1);
    check_val("conf_size", m_size, 1);
    check_val("conf_ids", m_ids, 256'hA);
    check_val("conf_cnt", n_conf, 1);
    step(1, 64'hB, 16'h0002, 16'h0000, 1, 0);
    step(1, 64'hB, 16'h0002, 16'h0000, 1, 0);
    check_val("conf_newrd", b_rd, 16'h0002);
    check_val("conf_emit", n_emit, 2);

    // Timeout of the lone txn 0xB
    idle(7);
    check_val("tmo_early", m_tvalid, 0);
    idle(1);
    check_val("tmo_vld", m_tvalid, 1);
    check_val("tmo_size", m_size, 1);
    check_val("tmo_cnt", n_to, 1);
    idle(11);
    check_val("idle_novld", m_tvalid, 0);
    check_val("idle_emit", n_emit, 3);

    // Backpressure holds the full batch and its masks
    for (int k = 0; k < 4; k++)
      step(1, 64'(16 + k), 16'(1) << k, 16'h0100 << k, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 64'h99, 16'h0001, '0, 0, 0);
    check_val("bp_rd", b_rd, 16'h000F);
    check_val("bp_emit", n_emit, 3);
    step(0, '0, '0, '0, 1, 0);
    check_val("bp_rd_clr", b_rd, 16'h0000);
    check_val("bp_wr_clr", b_wr, 16'h0000);
    check_val("bp_emit2", n_emit, 4);

    // Accept on the timeout cycle is kept in the batch
    step(1, 64'h21, 16'h0001, '0, 1, 0);
    idle(7);
    step(1, 64'h22, 16'h0002, '0, 1, 0);
    check_val("tacc_vld", m_tvalid, 1);
    check_val("tacc_size", m_size, 2);
    check_val("tacc_ids", m_ids, {64'd0, 64'd0, 64'h22, 64'h21});
    check_val("tacc_cnt", n_to, 2);
    idle(1);

    // Reset with a partial batch
    for (int k = 0; k < 3; k++) step(1, 64'(48 + k), 16'(1) << k, '0, 1, 0);
    step(0, '0, '0, '0, 1, 1);
    check_val("rst_size", m_size, 0);
    check_val("rst_rd", b_rd, 0);
    check_val("rst_vld", m_tvalid, 0);
    check_val("rst_emit", n_emit, 0);
    check_val("rst_conf", n_conf, 0);
    check_val("rst_tmo", n_to, 0);
    check_val("rst_rdy", s_tready, 1);

    // Randomized traffic with alternating dense/sparse phases
    for (int i = 0; i < 3000; i++) begin
      int vprob;
      logic [MD-1:0] rd, wr;
      vprob = ((i / 400) % 2 == 1) ? 12 : 70;
      rd = ($urandom_range(3) == 0) ? '0 : (16'(1) << $urandom_range(15));
      wr = ($urandom_range(2) == 0) ? '0 : (16'(1) << $urandom_range(15));
      if ($urandom_range(7) == 0) rd |= 16'(1) << $urandom_range(15);
      step($urandom_range(99) < vprob, {$urandom, $urandom}, rd, wr,
           $urandom_range(99) < 70, $urandom_range(599) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
